// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks shadow E/M/W
// records and drives forwarding selects, stall/flush controls and a stall counter.
module pipeline_hazard_unit #(
    parameter int unsigned REG_ADDR_W     = 4,
    parameter int unsigned ZERO_REG_EN    = 0,
    parameter int unsigned FLAG_HAZARD_EN = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_ra1,
    input  logic [REG_ADDR_W-1:0] d_ra2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  d_regwrite,
    input  logic                  d_memtoreg,
    input  logic                  d_flagswrite,
    input  logic                  d_uses_flags,
    input  logic                  branch_taken_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] ra1;
        logic [REG_ADDR_W-1:0] ra2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  flagswrite;
    } stage_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    stage_t e_q, m_q, w_q;
    stage_t d_rec;
    logic   lduse, flaghz, hold;

    // Producer s will write register r; a hard-wired r0 never matches.
    function automatic logic match(input stage_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.regwrite && (s.rd == r) &&
               !((ZERO_REG_EN != 0) && (r == '0));
    endfunction

    // Loads in M have no data yet, so only ALU results forward from M.
    function automatic logic [1:0] fwd_sel(input stage_t m, input stage_t w,
                                           input logic [REG_ADDR_W-1:0] r);
        if (match(m, r) && !m.memtoreg) return FWD_M;
        else if (match(w, r))           return FWD_W;
        else                            return FWD_RF;
    endfunction

    always_comb begin
        d_rec = '{valid: d_valid, ra1: d_ra1, ra2: d_ra2, rd: d_rd,
                  regwrite: d_regwrite, memtoreg: d_memtoreg,
                  flagswrite: d_flagswrite};
        lduse  = d_valid && e_q.valid && e_q.memtoreg &&
                 (match(e_q, d_ra1) || match(e_q, d_ra2));
        flaghz = (FLAG_HAZARD_EN != 0) && d_valid && d_uses_flags &&
                 ((e_q.valid && e_q.flagswrite) || (m_q.valid && m_q.flagswrite));
        hold   = !start || lduse || flaghz;
    end

    // A taken branch discards the wrong-path D instruction, overriding any hold.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        fwd_a_e = fwd_sel(m_q, w_q, e_q.ra1);
        fwd_b_e = fwd_sel(m_q, w_q, e_q.ra2);
        busy    = e_q.valid || m_q.valid || w_q.valid;
        if (reset) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            fwd_a_e = FWD_RF;
            fwd_b_e = FWD_RF;
            busy    = 1'b0;
        end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_count <= '0;
        end else begin
            e_q       <= d_rec;
            e_q.valid <= d_valid && !flush_e;
            m_q       <= e_q;
            w_q       <= m_q;
            if (stall_d && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // W source fields are carried for completeness but not consumed here.
    logic unused_fields;
    assign unused_fields = ^{w_q.ra1, w_q.ra2, w_q.memtoreg, w_q.flagswrite,
                             m_q.ra1, m_q.ra2};

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage RSA pipeline (F/D/E/M/W).
- Keeps its own shadow copy of the E, M and W stage records.
- Drives forwarding selects, stall and flush signals, and gates issue on start.
- Sits beside the datapath; the top-level processor wires it to the pipeline registers.
- Adds behaviour the current pipeline lacks: load-use stall, flag hazard stall, branch flush, and a stall performance counter.

Parameters:
REG_ADDR_W, 4, width of register specifiers.
ZERO_REG_EN, 0, if 1 register 0 is hard-wired: never forwarded, never causes hazards.
FLAG_HAZARD_EN, 1, if 1 a flag-consuming D instruction stalls while a flag writer is in E or M.
CNT_W, 16, width of the stall_count performance counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  run enable; while 0 no instruction issues from D
d_valid  in  1  D stage holds a real instruction
d_ra1  in  REG_ADDR_W  D source register 1
d_ra2  in  REG_ADDR_W  D source register 2
d_rd  in  REG_ADDR_W  D destination register
d_regwrite  in  1  D instruction writes the register file
d_memtoreg  in  1  D instruction is a load
d_flagswrite  in  1  D instruction writes flags
d_uses_flags  in  1  D instruction is conditional (reads flags)
branch_taken_e  in  1  branch resolved taken in E this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
flush_d  out  1  clear F/D register
flush_e  out  1  clear D/E register (insert bubble)
fwd_a_e  out  2  E operand A select: 00 regfile, 01 W result, 10 M ALU result
fwd_b_e  out  2  E operand B select, same encoding
busy  out  1  any valid instruction in E, M or W
stall_count  out  CNT_W  cycles with stall_d=1 since reset, saturating

Behaviour:
- Stage records: E, M and W each hold {valid, ra1, ra2, rd, regwrite, memtoreg, flagswrite}.
- Every cycle: W<=M, M<=E.
- E<=D record (valid=d_valid) unless flush_e=1, in which case E.valid<=0.
- Invalid records never match for any hazard or forwarding check.
- Match(s, r): s.valid & s.regwrite & s.rd==r & !(ZERO_REG_EN & r==0).
- fwd_x_e (combinational from registered state):
  - 10 if Match(M, E.rax) & !M.memtoreg;
  - else 01 if Match(W, E.rax);
  - else 00.
  - M has priority over W.
- lduse = d_valid & E.valid & E.memtoreg & (Match(E,d_ra1) | Match(E,d_ra2)).
- flaghz = FLAG_HAZARD_EN & d_valid & d_uses_flags & ((E.valid & E.flagswrite) | (M.valid & M.flagswrite)).
- hold = !start | lduse | flaghz.
- Priority: branch_taken_e > hold.
  - If branch_taken_e: flush_d=1, flush_e=1, stall_f=0, stall_d=0. The D instruction is wrong-path and is discarded, even if it has a hazard.
  - Else if hold: stall_f=1, stall_d=1, flush_d=0, flush_e=1.
  - Else all four are 0.
- Load-use stalls exactly 1 cycle: the load moves to M, after which the datapath forwards the result via W.
- Flag stall lasts until the flag writer leaves M: 2 cycles if the writer is in E, 1 cycle if it is in M.
- stall_count increments on every cycle with stall_d=1 and reset=0; it holds at all-ones, with no wrap.
- busy = E.valid | M.valid | W.valid.
- While reset=1 (applies on the edge, any time including mid-operation):
  - outputs: stall_f=1, stall_d=1, flush_d=1, flush_e=1, fwd_a_e=00, fwd_b_e=00, busy=0;
  - state: all records invalid, stall_count cleared to 0 on the edge.
- First cycle after reset with start=1: no stall; D issues normally.
- start deassert mid-run: issue freezes with bubbles into E; instructions already in E, M and W drain normally, and busy falls after 3 cycles.

Test Plan:
- Reset/start: reset 2 cycles, start=0 for 3 cycles -> stall_f=stall_d=flush_e=1, stall_count=3. Raise start -> stalls drop next cycle.
- Forwarding: ADD r3 then ADD r4=r3+r3 back-to-back -> fwd_a_e=fwd_b_e=10. One instruction gap -> 01. Both M and W write r3 -> 10.
- Load-use: LDR r2 followed by ADD r5=r2+r1 -> exactly one cycle of stall_f=stall_d=flush_e=1. Next cycle fwd_a_e=01, stall_count +1.
- Branch vs hazard: branch_taken_e=1 in the same cycle as a load-use condition -> flush_d=flush_e=1, stall_d=0, stall_count unchanged.
- Flag hazard: CMP then conditional branch in D with FLAG_HAZARD_EN=1 -> 2 stall cycles. With FLAG_HAZARD_EN=0 -> 0 stall cycles.
- ZERO_REG_EN=1 and saturation:
  - write r0 then read r0 -> fwd=00, no stall.
  - CNT_W=4, hold start=0 for 20 cycles -> stall_count=15 and holds.
  - reset mid-stall -> stall_count=0, busy=0.
